// File: rtl/call_return_controller_if.sv
// Request/response bundle between a call/return requester and call_return_controller.
// The requester drives the level requests and operands; the controller answers with
// single-cycle acks and the registered restored-frame values.
interface call_return_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  call_req;
    logic                  ret_req;
    logic [ADDR_WIDTH-1:0] ret_pc_in;
    logic [ADDR_WIDTH-1:0] tos_in;
    logic [DATA_WIDTH-1:0] ret_val_in;
    logic                  call_ack;
    logic                  ret_ack;
    logic [ADDR_WIDTH-1:0] ret_pc_out;
    logic [ADDR_WIDTH-1:0] ret_tos_out;
    logic [DATA_WIDTH-1:0] ret_val_out;

    modport master (
        output call_req, ret_req, ret_pc_in, tos_in, ret_val_in,
        input  call_ack, ret_ack, ret_pc_out, ret_tos_out, ret_val_out
    );

    modport slave (
        input  call_req, ret_req, ret_pc_in, tos_in, ret_val_in,
        output call_ack, ret_ack, ret_pc_out, ret_tos_out, ret_val_out
    );
endinterface

// File: rtl/call_return_controller.sv
// Call/return frame controller: pushes the caller PC/TOS onto an external frame stack
// on a call and restores them (plus a return value) on a return.
// Optional build macro CALL_STACK_GUARD_EN: enables overflow/underflow protection and
// the sticky err flag. Without it the stack pointer wraps modulo MAX_DEPTH and err is 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting; the only state that samples call_req / ret_req
// PUSH    | writing caller frame at stk_addr = depth
// POP_RD  | presenting stk_addr = depth-1 to the frame stack
// POP_CAP | capturing read data into ret_pc_out / ret_tos_out, depth--
// DONE    | pulsing call_ack or ret_ack for one cycle
module call_return_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_DEPTH  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    call_return_controller_if.slave cr,
    input  logic                    err_clr,
    input  logic [ADDR_WIDTH-1:0]   stk_rdata_pc,
    input  logic [ADDR_WIDTH-1:0]   stk_rdata_tos,
    output logic [ADDR_WIDTH-1:0]   stk_addr,
    output logic                    stk_we,
    output logic [ADDR_WIDTH-1:0]   stk_wdata_pc,
    output logic [ADDR_WIDTH-1:0]   stk_wdata_tos,
    output logic [ADDR_WIDTH-1:0]   depth,
    output logic                    busy,
    output logic                    err
);

    if (MAX_DEPTH >= (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("MAX_DEPTH must be below 2**ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH    = 3'd1,
        POP_RD  = 3'd2,
        POP_CAP = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LAST = ADDR_WIDTH'(MAX_DEPTH - 1);

    state_t                  state, state_nxt;
    logic                    op_is_call, op_is_call_nxt;
    logic [ADDR_WIDTH-1:0]   depth_r, depth_nxt;
    logic [ADDR_WIDTH-1:0]   depth_inc, depth_dec;
    logic                    stack_full, stack_empty;
    logic                    err_r, err_set;
    logic                    latch_val, latch_frame;
    logic [ADDR_WIDTH-1:0]   pc_out_r, tos_out_r;
    logic [DATA_WIDTH-1:0]   val_out_r;

    // The decrement always wraps; with the guard enabled a pop never starts at 0, so
    // the wrap only matters in the unguarded build.
    assign depth_dec = (depth_r == '0) ? DEPTH_LAST : depth_r - ONE;

`ifdef CALL_STACK_GUARD_EN
    localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = ADDR_WIDTH'(MAX_DEPTH);
    // Guarded depth may legally reach MAX_DEPTH, so no wrap on increment.
    assign depth_inc   = depth_r + ONE;
    assign stack_full  = (depth_r == DEPTH_MAX);
    assign stack_empty = (depth_r == '0);
`else
    assign depth_inc   = (depth_r == DEPTH_LAST) ? '0 : depth_r + ONE;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
`endif

    // State, operation type and stack pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_is_call <= 1'b0;
            depth_r    <= '0;
        end else begin
            state      <= state_nxt;
            op_is_call <= op_is_call_nxt;
            depth_r    <= depth_nxt;
        end
    end

    // Next-state decode; guarded overflow/underflow skip straight to DONE and flag err.
    always_comb begin
        state_nxt      = state;
        op_is_call_nxt = op_is_call;
        depth_nxt      = depth_r;
        err_set        = 1'b0;
        latch_val      = 1'b0;
        latch_frame    = 1'b0;
        case (state)
            IDLE: begin
                if (cr.call_req) begin
                    op_is_call_nxt = 1'b1;
                    if (stack_full) begin
                        err_set   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = PUSH;
                    end
                end else if (cr.ret_req) begin
                    op_is_call_nxt = 1'b0;
                    if (stack_empty) begin
                        err_set   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        latch_val = 1'b1;
                        state_nxt = POP_RD;
                    end
                end
            end
            PUSH: begin
                depth_nxt = depth_inc;
                state_nxt = DONE;
            end
            POP_RD: begin
                state_nxt = POP_CAP;
            end
            POP_CAP: begin
                latch_frame = 1'b1;
                depth_nxt   = depth_dec;
                state_nxt   = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Restored frame and return value; they hold until the next successful return.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out_r  <= '0;
            tos_out_r <= '0;
            val_out_r <= '0;
        end else begin
            if (latch_val) begin
                val_out_r <= cr.ret_val_in;
            end
            if (latch_frame) begin
                pc_out_r  <= stk_rdata_pc;
                tos_out_r <= stk_rdata_tos;
            end
        end
    end

    // Sticky error flag; a set in the same cycle as err_clr wins. In the unguarded
    // build err_set is constant 0, so this flop never leaves its reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (err_set) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    // Write strobe and acks are gated by reset so an interrupted operation has no effect.
    assign stk_we        = (state == PUSH) && !reset;
    assign stk_addr      = ((state == POP_RD) || (state == POP_CAP)) ? depth_dec : depth_r;
    assign stk_wdata_pc  = cr.ret_pc_in;
    assign stk_wdata_tos = cr.tos_in;

    assign cr.call_ack    = (state == DONE) &&  op_is_call && !reset;
    assign cr.ret_ack     = (state == DONE) && !op_is_call && !reset;
    assign cr.ret_pc_out  = pc_out_r;
    assign cr.ret_tos_out = tos_out_r;
    assign cr.ret_val_out = val_out_r;

    assign depth = depth_r;
    assign busy  = (state != IDLE);
    assign err   = err_r;

endmodule

// File: tb/tb_call_return_controller.sv
// Directed self-checking bench for call_return_controller with a behavioural frame stack.
module tb_call_return_controller;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int MD = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          err_clr = 1'b0;
    logic [AW-1:0] stk_rdata_pc, stk_rdata_tos;
    logic [AW-1:0] stk_addr, stk_wdata_pc, stk_wdata_tos, depth;
    logic          stk_we, busy, err;

    int passed = 0;
    int total  = 0;

    logic [AW-1:0] mem_pc  [0:127];
    logic [AW-1:0] mem_tos [0:127];

    call_return_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cr();

    call_return_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DEPTH(MD)) dut (
        .clk           (clk),
        .reset         (reset),
        .cr            (cr),
        .err_clr       (err_clr),
        .stk_rdata_pc  (stk_rdata_pc),
        .stk_rdata_tos (stk_rdata_tos),
        .stk_addr      (stk_addr),
        .stk_we        (stk_we),
        .stk_wdata_pc  (stk_wdata_pc),
        .stk_wdata_tos (stk_wdata_tos),
        .depth         (depth),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stk_we) begin
            mem_pc[stk_addr[6:0]]  <= stk_wdata_pc;
            mem_tos[stk_addr[6:0]] <= stk_wdata_tos;
        end
        stk_rdata_pc  <= mem_pc[stk_addr[6:0]];
        stk_rdata_tos <= mem_tos[stk_addr[6:0]];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cr.call_req = 1'b0;
        cr.ret_req = 1'b0;
        err_clr = 1'b0;
        step;
        step;
        reset = 1'b0;
    endtask

    // Issue a call from IDLE; lat = edges from drive until call_ack seen (20 = timeout).
    task automatic do_call(input logic [AW-1:0] pc, input logic [AW-1:0] tos,
                           output int lat, output int we_cnt, output logic err_ack);
        cr.call_req = 1'b1;
        cr.ret_pc_in = pc;
        cr.tos_in = tos;
        lat = 0;
        we_cnt = 0;
        err_ack = 1'b0;
        while (lat < 20) begin
            step;
            lat++;
            if (stk_we) we_cnt++;
            if (cr.call_ack) begin
                err_ack = err;
                break;
            end
        end
        cr.call_req = 1'b0;
        step;
    endtask

    task automatic do_ret(input logic [DW-1:0] val, output int lat, output int we_cnt,
                          output logic err_ack);
        cr.ret_req = 1'b1;
        cr.ret_val_in = val;
        lat = 0;
        we_cnt = 0;
        err_ack = 1'b0;
        while (lat < 20) begin
            step;
            lat++;
            if (stk_we) we_cnt++;
            if (cr.ret_ack) begin
                err_ack = err;
                break;
            end
        end
        cr.ret_req = 1'b0;
        step;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (depth !== 12'h000) $display("FAIL reset_depth: got %h expected 000", depth); else passed++;
        total++; if ({busy, err, stk_we, cr.call_ack, cr.ret_ack} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, err, stk_we, cr.call_ack, cr.ret_ack});
        else passed++;
        total++; if ({cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out} !== 32'h0)
            $display("FAIL reset_outputs: got %h expected 0", {cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out});
        else passed++;
        total++; if (stk_addr !== 12'h000) $display("FAIL reset_addr: got %h expected 000", stk_addr); else passed++;
    endtask

    task automatic test_single_call;
        do_reset;
        cr.call_req = 1'b1;
        cr.ret_pc_in = 12'h123;
        cr.tos_in = 12'h045;
        step;
        total++; if ({stk_we, stk_addr, stk_wdata_pc, stk_wdata_tos} !== {1'b1, 12'h000, 12'h123, 12'h045})
            $display("FAIL call_push: got we=%b addr=%h pc=%h tos=%h expected 1/000/123/045",
                     stk_we, stk_addr, stk_wdata_pc, stk_wdata_tos);
        else passed++;
        total++; if ({busy, cr.call_ack} !== 2'b10) $display("FAIL call_push_busy: got %b expected 10", {busy, cr.call_ack}); else passed++;
        step;
        total++; if ({cr.call_ack, cr.ret_ack, stk_we} !== 3'b100)
            $display("FAIL call_ack_lat2: got %b expected 100", {cr.call_ack, cr.ret_ack, stk_we});
        else passed++;
        total++; if (depth !== 12'h001) $display("FAIL call_depth: got %h expected 001", depth); else passed++;
        cr.call_req = 1'b0;
        step;
        total++; if ({busy, cr.call_ack, stk_addr} !== {2'b00, 12'h001})
            $display("FAIL call_idle: got busy=%b ack=%b addr=%h expected 0/0/001", busy, cr.call_ack, stk_addr);
        else passed++;
        total++; if ({mem_pc[0], mem_tos[0]} !== {12'h123, 12'h045})
            $display("FAIL call_mem: got %h/%h expected 123/045", mem_pc[0], mem_tos[0]);
        else passed++;
    endtask

    task automatic test_nested;
        int lat, wc;
        logic e;
        logic [AW-1:0] cpc [3];
        logic [AW-1:0] ctos [3];
        logic [DW-1:0] vals [3];
        cpc = '{12'h010, 12'h020, 12'h030};
        ctos = '{12'h110, 12'h120, 12'h130};
        vals = '{8'hA1, 8'hA2, 8'hA3};
        do_reset;
        for (int i = 0; i < 3; i++) begin
            do_call(cpc[i], ctos[i], lat, wc, e);
            total++; if (lat !== 2 || wc !== 1)
                $display("FAIL nested_call[%0d]: got lat=%0d we=%0d expected 2/1", i, lat, wc);
            else passed++;
        end
        total++; if (depth !== 12'h003) $display("FAIL nested_depth3: got %h expected 003", depth); else passed++;
        for (int i = 0; i < 3; i++) begin
            do_ret(vals[i], lat, wc, e);
            total++; if (lat !== 3) $display("FAIL nested_ret_lat[%0d]: got %0d expected 3", i, lat); else passed++;
            total++; if ({cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out} !== {cpc[2-i], ctos[2-i], vals[i]})
                $display("FAIL nested_ret[%0d]: got %h/%h/%h expected %h/%h/%h", i, cr.ret_pc_out,
                         cr.ret_tos_out, cr.ret_val_out, cpc[2-i], ctos[2-i], vals[i]);
            else passed++;
        end
        total++; if (depth !== 12'h000) $display("FAIL nested_depth0: got %h expected 000", depth); else passed++;
    endtask

    task automatic test_priority;
        int lat, wc, n;
        logic e, saw_ret;
        do_reset;
        do_call(12'h111, 12'h011, lat, wc, e);
        do_call(12'h222, 12'h022, lat, wc, e);
        cr.call_req = 1'b1;
        cr.ret_req = 1'b1;
        cr.ret_pc_in = 12'h333;
        cr.tos_in = 12'h033;
        cr.ret_val_in = 8'h5C;
        lat = 0;
        saw_ret = 1'b0;
        while (lat < 20) begin
            step;
            lat++;
            if (cr.ret_ack) saw_ret = 1'b1;
            if (cr.call_ack) break;
        end
        total++; if (lat !== 2 || saw_ret !== 1'b0)
            $display("FAIL prio_call_first: got lat=%0d ret_ack_seen=%b expected 2/0", lat, saw_ret);
        else passed++;
        total++; if (depth !== 12'h003) $display("FAIL prio_depth3: got %h expected 003", depth); else passed++;
        cr.call_req = 1'b0;
        n = 0;
        while (n < 20) begin
            step;
            n++;
            if (cr.ret_ack) break;
        end
        cr.ret_req = 1'b0;
        total++; if (n !== 4) $display("FAIL prio_ret_after_idle: got %0d cycles expected 4", n); else passed++;
        step;
        total++; if ({cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out, depth} !== {12'h333, 12'h033, 8'h5C, 12'h002})
            $display("FAIL prio_ret_data: got %h/%h/%h depth=%h expected 333/033/5c/002",
                     cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out, depth);
        else passed++;
    endtask

`ifdef CALL_STACK_GUARD_EN
    task automatic test_guard;
        int lat, wc;
        logic e;
        do_reset;
        for (int i = 0; i < MD; i++) begin
            do_call(AW'(i), AW'(i + 12'h100), lat, wc, e);
        end
        total++; if (depth !== 12'd64) $display("FAIL guard_depth64: got %0d expected 64", depth); else passed++;
        do_call(12'hFFF, 12'hEEE, lat, wc, e);
        total++; if (lat !== 1 || wc !== 0 || e !== 1'b1)
            $display("FAIL guard_overflow: got lat=%0d we=%0d err=%b expected 1/0/1", lat, wc, e);
        else passed++;
        total++; if (depth !== 12'd64 || err !== 1'b1)
            $display("FAIL guard_overflow_hold: got depth=%0d err=%b expected 64/1", depth, err);
        else passed++;
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        total++; if (err !== 1'b0) $display("FAIL guard_err_clr: got %b expected 0", err); else passed++;
        do_reset;
        do_call(12'h0AB, 12'h0CD, lat, wc, e);
        do_ret(8'h77, lat, wc, e);
        do_ret(8'h99, lat, wc, e);
        total++; if (lat !== 1 || e !== 1'b1)
            $display("FAIL guard_underflow: got lat=%0d err=%b expected 1/1", lat, e);
        else passed++;
        total++; if ({cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out, depth} !== {12'h0AB, 12'h0CD, 8'h77, 12'h000})
            $display("FAIL guard_underflow_hold: got %h/%h/%h depth=%h expected 0ab/0cd/77/000",
                     cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out, depth);
        else passed++;
    endtask
`else
    task automatic test_wrap;
        int lat, wc;
        logic e;
        do_reset;
        cr.ret_req = 1'b1;
        cr.ret_val_in = 8'h5A;
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        total++; if ({stk_we, stk_addr} !== {1'b0, 12'd63})
            $display("FAIL wrap_pop_addr: got we=%b addr=%0d expected 0/63", stk_we, stk_addr);
        else passed++;
        step;
        step;
        total++; if ({cr.ret_ack, depth, err} !== {1'b1, 12'd63, 1'b0})
            $display("FAIL wrap_pop_done: got ack=%b depth=%0d err=%b expected 1/63/0", cr.ret_ack, depth, err);
        else passed++;
        cr.ret_req = 1'b0;
        step;
        total++; if (cr.ret_val_out !== 8'h5A) $display("FAIL wrap_ret_val: got %h expected 5a", cr.ret_val_out); else passed++;
        do_call(12'h3F3, 12'h3F4, lat, wc, e);
        total++; if (depth !== 12'h000 || err !== 1'b0)
            $display("FAIL wrap_push: got depth=%0d err=%b expected 0/0", depth, err);
        else passed++;
        total++; if (mem_pc[63] !== 12'h3F3) $display("FAIL wrap_push_mem: got %h expected 3f3", mem_pc[63]); else passed++;
    endtask
`endif

    task automatic test_reset_mid_push;
        int lat, wc;
        logic e;
        logic [AW-1:0] old_pc;
        do_reset;
        do_call(12'h0EE, 12'h0FF, lat, wc, e);
        old_pc = mem_pc[1];
        cr.call_req = 1'b1;
        cr.ret_pc_in = 12'h7E7;
        cr.tos_in = 12'h7E8;
        step;
        reset = 1'b1;
        cr.call_req = 1'b0;
        #1;
        total++; if (stk_we !== 1'b0) $display("FAIL rst_push_we: got %b expected 0", stk_we); else passed++;
        step;
        reset = 1'b0;
        total++; if ({busy, cr.call_ack, depth} !== {2'b00, 12'h000})
            $display("FAIL rst_push_state: got busy=%b ack=%b depth=%h expected 0/0/000", busy, cr.call_ack, depth);
        else passed++;
        total++; if (mem_pc[1] !== old_pc) $display("FAIL rst_push_nowrite: got %h expected %h", mem_pc[1], old_pc); else passed++;
    endtask

    task automatic test_reset_mid_pop;
        int lat, wc, acks;
        logic e;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            do_call(AW'(12'h100 + i), AW'(12'h200 + i), lat, wc, e);
        end
        do_ret(8'h3C, lat, wc, e);
        total++; if ({cr.ret_pc_out, depth} !== {12'h105, 12'h005})
            $display("FAIL pre_rst_pop: got pc=%h depth=%h expected 105/005", cr.ret_pc_out, depth);
        else passed++;
        cr.ret_req = 1'b1;
        cr.ret_val_in = 8'h4D;
        step;
        total++; if ({busy, stk_addr} !== {1'b1, 12'h004})
            $display("FAIL rst_pop_rd: got busy=%b addr=%h expected 1/004", busy, stk_addr);
        else passed++;
        reset = 1'b1;
        cr.ret_req = 1'b0;
        step;
        total++; if ({busy, cr.ret_ack, depth} !== {2'b00, 12'h000})
            $display("FAIL rst_pop_state: got busy=%b ack=%b depth=%h expected 0/0/000", busy, cr.ret_ack, depth);
        else passed++;
        total++; if ({cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out} !== 32'h0)
            $display("FAIL rst_pop_outputs: got %h/%h/%h expected 0/0/0", cr.ret_pc_out, cr.ret_tos_out, cr.ret_val_out);
        else passed++;
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step;
            if (cr.ret_ack) acks++;
        end
        total++; if (acks !== 0) $display("FAIL rst_pop_no_ack: got %0d acks expected 0", acks); else passed++;
    endtask

    initial begin
        cr.call_req = 1'b0;
        cr.ret_req = 1'b0;
        cr.ret_pc_in = '0;
        cr.tos_in = '0;
        cr.ret_val_in = '0;
        test_reset;
        test_single_call;
        test_nested;
        test_priority;
`ifdef CALL_STACK_GUARD_EN
        test_guard;
`else
        test_wrap;
`endif
        test_reset_mid_push;
        test_reset_mid_pop;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/call_return_controller.md
CALL_RETURN_CONTROLLER -- requirements
Module: call_return_controller

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, return-value width; ADDR_WIDTH, default 12, PC/TOS/stack-address width; MAX_DEPTH, default 64, max call nesting, SHALL be < 2**ADDR_WIDTH.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 call_req  in  1  function-call request, level, held until call_ack.
REQ-005 ret_req  in  1  function-return request, level, held until ret_ack.
REQ-006 ret_pc_in  in  ADDR_WIDTH  caller return PC pushed on call.
REQ-007 tos_in  in  ADDR_WIDTH  caller operand-stack TOS pushed on call.
REQ-008 ret_val_in  in  DATA_WIDTH  return value presented with ret_req.
REQ-009 err_clr  in  1  clears err.
REQ-010 stk_rdata_pc, stk_rdata_tos  in  ADDR_WIDTH each  frame-stack read data, valid 1 cycle after stk_addr.
REQ-011 stk_addr  out  ADDR_WIDTH  frame-stack address.
REQ-012 stk_we  out  1  frame-stack write strobe.
REQ-013 stk_wdata_pc, stk_wdata_tos  out  ADDR_WIDTH each  frame-stack write data.
REQ-014 call_ack, ret_ack  out  1 each  single-cycle completion pulses.
REQ-015 ret_pc_out, ret_tos_out  out  ADDR_WIDTH each  restored caller PC/TOS, registered.
REQ-016 ret_val_out  out  DATA_WIDTH  registered return value.
REQ-017 depth  out  ADDR_WIDTH  current nesting count (stack pointer).
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err  out  1  sticky overflow/underflow flag.

Function
REQ-020 FSM states SHALL be IDLE, PUSH, POP_RD, POP_CAP, DONE.
REQ-021 IDLE: requests SHALL be sampled only here; call_req SHALL take priority over ret_req when both high.
REQ-022 Accepted call: PUSH for one cycle with stk_we=1, stk_addr=depth, stk_wdata_pc=ret_pc_in, stk_wdata_tos=tos_in; depth SHALL increment at PUSH exit; then DONE.
REQ-023 Accepted return: ret_val_in SHALL be latched into ret_val_out at accept; POP_RD drives stk_addr=depth-1, stk_we=0; POP_CAP latches stk_rdata_pc/stk_rdata_tos into ret_pc_out/ret_tos_out and decrements depth; then DONE.
REQ-024 DONE SHALL pulse the matching ack for exactly one cycle and return to IDLE; requester SHALL drop req in ack cycle; minimum one IDLE cycle between operations.
REQ-025 Latency: call_ack SHALL assert 2 cycles after accept edge, ret_ack 3 cycles after.
REQ-026 stk_we SHALL be high only in PUSH; stk_addr SHALL equal depth when idle.
REQ-027 Outputs ret_pc_out, ret_tos_out, ret_val_out SHALL hold value until next successful return.
REQ-028 err_clr SHALL clear err in IDLE and other states; if an error sets in the same cycle, set SHALL win.

Reset
REQ-029 Reset SHALL force IDLE, depth=0, err=0, acks=0, stk_we=0, ret_pc_out=ret_tos_out=0, ret_val_out=0, busy=0, overriding any operation in progress; a PUSH interrupted by reset SHALL not write.
REQ-030 Stack memory contents SHALL not be cleared by reset.

Configuration
REQ-031 With CALL_STACK_GUARD_EN defined: call with depth==MAX_DEPTH SHALL skip PUSH (no write, depth unchanged), go to DONE, set err in ack cycle; return with depth==0 SHALL skip POP (outputs and ret_val_out unchanged), set err with ack.
REQ-032 Without CALL_STACK_GUARD_EN: err SHALL be tied 0; depth SHALL wrap modulo MAX_DEPTH on both increment and decrement.

Verification
REQ-033 Reset, then call with ret_pc_in=0x123, tos_in=0x045 -> stk_we one cycle at stk_addr=0 with those data, call_ack 2 cycles after accept, depth=1.
REQ-034 Three calls (PC 0x010,0x020,0x030) then three returns with ret_val_in 0xA1,0xA2,0xA3 -> ret_pc_out 0x030,0x020,0x010 in order, ret_val_out matches each, ret_ack 3 cycles after accept, depth back to 0.
REQ-035 call_req and ret_req high together at depth=2 -> call served, depth=3, ret served next after idle cycle.
REQ-036 Guard on: 64 calls then 65th -> no stk_we, depth=64, err=1 with call_ack; err_clr -> err=0; at depth=0 return -> err=1, ret_pc_out unchanged.
REQ-037 Guard off: return at depth=0 -> depth=63, stk_addr read 63, err stays 0.
REQ-038 Reset asserted during POP_RD at depth=5 -> next cycle IDLE, depth=0, no ret_ack, outputs 0.
